instruction_sequencer: RTL and testbench
========================================

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 SHALL have parameter ALU_TIMEOUT, default 15, meaning the maximum number of WAIT cycles allowed for alu_done (range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port instr, input, 8 bits: instruction word; op=[7:4], sel_a=[3:2], sel_b=[1:0].
REQ-005 SHALL have port instr_valid, input, 1 bit: instr is offered.
REQ-006 SHALL have port instr_ready, output, 1 bit: the sequencer accepts instr this cycle.
REQ-007 SHALL have port alu_op, output, 4 bits: the ALU operation code.
REQ-008 SHALL have port alu_start, output, 1 bit: single-cycle ALU launch pulse.
REQ-009 SHALL have port alu_done, input, 1 bit: the ALU result is valid.
REQ-010 SHALL have ports src_a_sel and src_b_sel, output, 2 bits each: operand source, 00=external, 01=a_reg, 10=b_reg, 11=out_reg.
REQ-011 SHALL have ports latch_a, latch_b and latch_out, output, 1 bit each: single-cycle register write strobes.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have port err, output, 1 bit: sticky error flag.
REQ-014 SHALL have port err_clr, input, 1 bit: clears err.
REQ-015 SHALL have port instr_count, output, 8 bits: number of retired instructions.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, DECODE, EXEC, WAIT, WB; all outputs SHALL be decoded from the registered state and the IR.
REQ-017 IDLE: instr_ready=1; on a cycle where instr_valid=1 and instr_ready=1, SHALL capture instr into the IR and go to DECODE; otherwise SHALL stay in IDLE.
REQ-018 instr_ready SHALL be 0 in every state except IDLE; instr_valid in those states SHALL be ignored.
REQ-019 DECODE (1 cycle): op 0000-0111 -> EXEC; op 1000-1011 -> WB; op 1100-1111 -> set err, retire nothing, go to IDLE.
REQ-020 EXEC (1 cycle): alu_start=1, alu_op=IR[7:4], then go to WAIT; alu_start SHALL be 0 in all other states.
REQ-021 WAIT: alu_op SHALL be held; alu_done=1 -> WB; alu_done SHALL be sampled only in WAIT and ignored elsewhere.
REQ-022 WAIT timeout: an 8-bit counter SHALL clear on WAIT entry and increment each WAIT cycle; if it reaches ALU_TIMEOUT with alu_done=0, the FSM SHALL set err and go to IDLE without writeback; alu_done on the same cycle as the timeout SHALL win (go to WB).
REQ-023 WB (1 cycle): SHALL pulse exactly one strobe, then go to IDLE; ALU ops -> latch_out; 1000 move -> latch_b with src_a_sel=01; 1001 load a -> latch_a with src_a_sel=00; 1010 load b -> latch_b with src_b_sel=00; 1011 output a -> latch_out with src_a_sel=01.
REQ-024 For ALU ops, src_a_sel=IR[3:2] and src_b_sel=IR[1:0] SHALL hold from DECODE through WB; in IDLE both SHALL be 00.
REQ-025 instr_count SHALL increment by 1 on each WB cycle and wrap 255->0; aborted or illegal instructions SHALL NOT count.
REQ-026 err SHALL set on an illegal op or timeout and clear on err_clr=1; a set event and err_clr in the same cycle SHALL leave err=1; err SHALL NOT stall the FSM.
REQ-027 Latency: a non-ALU instruction accepted at edge N SHALL reach DECODE at N, WB at N+1, and IDLE at N+2; an ALU instruction SHALL take 3 cycles plus the number of WAIT cycles.
REQ-028 alu_op SHALL be 0000 outside EXEC and WAIT.

Reset
REQ-029 While rst_n=0, the block SHALL be asynchronously in IDLE with IR=0, timeout counter=0, instr_count=0 and err=0, and all outputs at 0 except instr_ready=1.
REQ-030 Reset mid-operation (any state) SHALL abort immediately with no strobe, and the in-flight instruction SHALL be lost; the first accept after release SHALL be allowed on the first posedge with rst_n=1.

Verification
REQ-031 Load a, instr=0x90: accept -> latch_a pulse 2 cycles later with src_a_sel=00; instr_count 0->1; busy high for 2 cycles.
REQ-032 Add, instr=0x06, with alu_done 3 cycles after alu_start -> alu_start 1 cycle, alu_op=0000 held, src_a_sel=01, src_b_sel=10, latch_out 1 cycle after done.
REQ-033 instr=0xC0 -> err=1, no strobe, instr_count unchanged; err_clr together with a second 0xC0 -> err stays 1.
REQ-034 ALU op with alu_done never asserted, ALU_TIMEOUT=15 -> err=1 after 15 WAIT cycles, no latch_out, return to IDLE.
REQ-035 256 back-to-back 0xB0 with instr_valid held high -> instr_count wraps to 0, one accept every 3 cycles, instr_ready low while busy.
REQ-036 rst_n asserted during WAIT -> immediate IDLE with all strobes 0; a later alu_done pulse is ignored.

Source files
------------

// File: rtl/instruction_sequencer_if.sv
// Instruction-offer handshake plus the ALU control and register-strobe bundle
// driven by the instruction sequencer.
interface instruction_sequencer_if;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] alu_op;
  logic       alu_start;
  logic       alu_done;
  logic [1:0] src_a_sel;
  logic [1:0] src_b_sel;
  logic       latch_a;
  logic       latch_b;
  logic       latch_out;

  modport master (
    output instr, instr_valid, alu_done,
    input  instr_ready, alu_op, alu_start, src_a_sel, src_b_sel,
           latch_a, latch_b, latch_out
  );

  modport slave (
    input  instr, instr_valid, alu_done,
    output instr_ready, alu_op, alu_start, src_a_sel, src_b_sel,
           latch_a, latch_b, latch_out
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Five-state Moore sequencer: fetches an 8-bit instruction, launches the ALU,
// waits for completion with a timeout, and issues one register write strobe.
module instruction_sequencer #(
  parameter int unsigned ALU_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  instruction_sequencer_if.slave bus,
  input  logic                   err_clr,
  output logic                   busy,
  output logic                   err,
  output logic [7:0]             instr_count
);
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef struct packed {
    logic       instr_ready;
    logic       busy;
    logic [3:0] alu_op;
    logic       alu_start;
    logic [1:0] src_a_sel;
    logic [1:0] src_b_sel;
    logic       latch_a;
    logic       latch_b;
    logic       latch_out;
  } out_t;

  localparam out_t OUT_IDLE_C = '{instr_ready: 1'b1, busy: 1'b0, alu_op: 4'h0,
                                  alu_start: 1'b0, src_a_sel: 2'b00, src_b_sel: 2'b00,
                                  latch_a: 1'b0, latch_b: 1'b0, latch_out: 1'b0};
  localparam out_t OUT_BUSY_C = '{instr_ready: 1'b0, busy: 1'b1, alu_op: 4'h0,
                                  alu_start: 1'b0, src_a_sel: 2'b00, src_b_sel: 2'b00,
                                  latch_a: 1'b0, latch_b: 1'b0, latch_out: 1'b0};
  // Count value seen during the last permitted WAIT cycle.
  localparam logic [7:0] WAIT_LAST_C = 8'(ALU_TIMEOUT - 32'd1);

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op[3:2] == 2'b11);
  endfunction

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] ir_r;
  logic [7:0] ir_nxt_s;
  logic [7:0] wait_cnt_r;
  logic [7:0] instr_count_r;
  logic       err_r;
  logic       err_set_s;
  logic       accept_s;
  logic       timeout_s;
  out_t       out_r;
  out_t       out_nxt_s;

  assign accept_s  = bus.instr_valid & out_r.instr_ready;
  assign timeout_s = (wait_cnt_r == WAIT_LAST_C);

  // Next-state, IR capture and error-set decode
  always_comb begin
    state_nxt_s = state_r;
    ir_nxt_s    = ir_r;
    err_set_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_DECODE;
          ir_nxt_s    = bus.instr;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (is_illegal_op(ir_r[7:4])) begin
          state_nxt_s = ST_IDLE;
          err_set_s   = 1'b1;
        end else if (is_alu_op(ir_r[7:4])) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_WB;
        end
      end
      ST_EXEC: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        // A completion arriving on the timeout cycle still wins.
        if (bus.alu_done) begin
          state_nxt_s = ST_WB;
        end else if (timeout_s) begin
          state_nxt_s = ST_IDLE;
          err_set_s   = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_WB:   state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state and IR, so the outputs can be registered
  always_comb begin
    out_nxt_s = OUT_BUSY_C;
    case (state_nxt_s)
      ST_IDLE: out_nxt_s = OUT_IDLE_C;
      ST_DECODE, ST_EXEC, ST_WAIT: begin
        if (is_alu_op(ir_nxt_s[7:4])) begin
          out_nxt_s.src_a_sel = ir_nxt_s[3:2];
          out_nxt_s.src_b_sel = ir_nxt_s[1:0];
        end else begin
          out_nxt_s.src_a_sel = 2'b00;
        end
        if (state_nxt_s != ST_DECODE) begin
          out_nxt_s.alu_op = ir_nxt_s[7:4];
        end else begin
          out_nxt_s.alu_op = 4'h0;
        end
        out_nxt_s.alu_start = (state_nxt_s == ST_EXEC);
      end
      ST_WB: begin
        if (is_alu_op(ir_nxt_s[7:4])) begin
          out_nxt_s.src_a_sel = ir_nxt_s[3:2];
          out_nxt_s.src_b_sel = ir_nxt_s[1:0];
          out_nxt_s.latch_out = 1'b1;
        end else begin
          case (ir_nxt_s[5:4])
            2'b00: begin out_nxt_s.src_a_sel = 2'b01; out_nxt_s.latch_b   = 1'b1; end
            2'b01: begin out_nxt_s.src_a_sel = 2'b00; out_nxt_s.latch_a   = 1'b1; end
            2'b10: begin out_nxt_s.src_b_sel = 2'b00; out_nxt_s.latch_b   = 1'b1; end
            default: begin out_nxt_s.src_a_sel = 2'b01; out_nxt_s.latch_out = 1'b1; end
          endcase
        end
      end
      default: out_nxt_s = OUT_IDLE_C;
    endcase
  end

  // State, instruction register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ir_r    <= 8'h00;
      out_r   <= OUT_IDLE_C;
    end else begin
      state_r <= state_nxt_s;
      ir_r    <= ir_nxt_s;
      out_r   <= out_nxt_s;
    end
  end

  // WAIT-cycle counter, cleared on the cycle that enters WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= 8'h00;
    end else if (state_r == ST_EXEC) begin
      wait_cnt_r <= 8'h00;
    end else if (state_r == ST_WAIT) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Retired-instruction counter and sticky error flag (set beats clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count_r <= 8'h00;
      err_r         <= 1'b0;
    end else begin
      if (state_r == ST_WB) begin
        instr_count_r <= instr_count_r + 8'd1;
      end else begin
        instr_count_r <= instr_count_r;
      end
      if (err_set_s) begin
        err_r <= 1'b1;
      end else if (err_clr) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign bus.instr_ready = out_r.instr_ready;
  assign bus.alu_op      = out_r.alu_op;
  assign bus.alu_start   = out_r.alu_start;
  assign bus.src_a_sel   = out_r.src_a_sel;
  assign bus.src_b_sel   = out_r.src_b_sel;
  assign bus.latch_a     = out_r.latch_a;
  assign bus.latch_b     = out_r.latch_b;
  assign bus.latch_out   = out_r.latch_out;
  assign busy            = out_r.busy;
  assign err             = err_r;
  assign instr_count     = instr_count_r;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized scoreboard bench for instruction_sequencer: each issued instruction
// pushes its expected outcome; a monitor checks every busy period when it ends.
module tb_instruction_sequencer;
  localparam int T_C = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       err_clr;
  logic       busy;
  logic       err;
  logic [7:0] instr_count;

  instruction_sequencer_if bus ();

  instruction_sequencer #(.ALU_TIMEOUT(T_C)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .err_clr     (err_clr),
    .busy        (busy),
    .err         (err),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         busy_len;
    int         op_lo;
    int         op_hi;
    int         start_pos;
    int         strobe_pos;
    logic [3:0] op;
    logic [2:0] strobe;     // {latch_a, latch_b, latch_out}
    logic       alu;
    logic       chk_sa;
    logic       chk_sb;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [7:0] count;
    logic       err;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_count;
  logic       model_err;
  int         alu_k;
  logic       stray_req;
  logic       mon_en;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Outcome of one instruction from the architectural rules: k is the WAIT
  // cycle carrying alu_done (0 = never), clr is err_clr during decode.
  function automatic exp_t model(input logic [7:0] ins, input int k, input logic clr);
    exp_t e;
    e.op = ins[7:4];  e.alu = ~ins[7];
    e.strobe = 3'b000; e.strobe_pos = -1; e.start_pos = -1;
    e.op_lo = -1; e.op_hi = -2; e.chk_sa = 1'b0; e.chk_sb = 1'b0;
    e.sa = ins[3:2];  e.sb = ins[1:0];
    if (ins[7:6] == 2'b11) begin
      e.busy_len = 1;
      model_err  = 1'b1;
    end else begin
      if (clr) model_err = 1'b0;
      if (!e.alu) begin
        e.busy_len = 2; e.strobe_pos = 1;
        model_count = model_count + 8'd1;
        case (ins[5:4])
          2'b00:   begin e.strobe = 3'b010; e.chk_sa = 1'b1; e.sa = 2'b01; end
          2'b01:   begin e.strobe = 3'b100; e.chk_sa = 1'b1; e.sa = 2'b00; end
          2'b10:   begin e.strobe = 3'b010; e.chk_sb = 1'b1; e.sb = 2'b00; end
          default: begin e.strobe = 3'b001; e.chk_sa = 1'b1; e.sa = 2'b01; end
        endcase
      end else begin
        e.start_pos = 1; e.op_lo = 1;
        if (k >= 1 && k <= T_C) begin
          e.busy_len = 3 + k; e.op_hi = e.busy_len - 2;
          e.strobe = 3'b001; e.strobe_pos = e.busy_len - 1;
          model_count = model_count + 8'd1;
        end else begin
          e.busy_len = 2 + T_C; e.op_hi = e.busy_len - 1;
          model_err = 1'b1;
        end
      end
    end
    e.count = model_count;
    e.err   = model_err;
    return e;
  endfunction

  task automatic issue(input logic [7:0] ins, input int k, input logic clr);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.instr_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.instr_ready) begin
      check("ready_timeout", 0, 1);
    end else begin
      alu_k = k;
      sb_q.push_back(model(ins, k, clr));
      bus.instr = ins;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      bus.instr = 8'($urandom);
      err_clr = clr;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", sb_q.size(), 0);
  endtask

  // ALU responder: raises alu_done in the requested WAIT cycle, or a stray pulse on demand
  initial begin
    bus.alu_done = 1'b0;
    forever begin
      @(negedge clk);
      if (stray_req) begin
        bus.alu_done = 1'b1;
        @(negedge clk);
        bus.alu_done = 1'b0;
      end else if (bus.alu_start && alu_k > 0) begin
        repeat (alu_k) @(posedge clk);
        #1 bus.alu_done = 1'b1;
        @(posedge clk);
        #1 bus.alu_done = 1'b0;
      end
    end
  end

  // Monitor: per-cycle invariants and a scoreboard pop at the end of each busy period
  initial begin
    int         pos;
    int         bad;
    int         st_n;
    logic [2:0] st_mask;
    logic       prev_busy;
    logic [3:0] exp_op;
    exp_t       e;
    pos = 0; bad = 0; st_n = 0; st_mask = 3'b000; prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        pos = 0; bad = 0; st_n = 0; st_mask = 3'b000; prev_busy = 1'b0;
      end else begin
        check("ready_vs_busy", int'(bus.instr_ready), int'(!busy));
        if (busy) begin
          if (sb_q.size() == 0) begin
            check("busy_without_instr", 1, 0);
          end else begin
            e = sb_q[0];
            exp_op = (pos >= e.op_lo && pos <= e.op_hi) ? e.op : 4'h0;
            if (bus.alu_op != exp_op) bad++;
            if (bus.alu_start != (pos == e.start_pos)) bad++;
            if ({bus.latch_a, bus.latch_b, bus.latch_out} != 3'b000) begin
              st_n++;
              st_mask = st_mask | {bus.latch_a, bus.latch_b, bus.latch_out};
              if (pos != e.strobe_pos) bad++;
              if (e.chk_sa && bus.src_a_sel != e.sa) bad++;
              if (e.chk_sb && bus.src_b_sel != e.sb) bad++;
            end
            if (e.alu && (bus.src_a_sel != e.sa || bus.src_b_sel != e.sb)) bad++;
          end
          pos++;
        end else begin
          check("idle_outputs", int'({bus.alu_op, bus.alu_start, bus.latch_a, bus.latch_b,
                                      bus.latch_out, bus.src_a_sel, bus.src_b_sel}), 0);
          if (prev_busy) begin
            if (sb_q.size() == 0) begin
              check("retire_without_instr", 1, 0);
            end else begin
              e = sb_q.pop_front();
              check("busy_cycles", pos, e.busy_len);
              check("strobe_kind", int'(st_mask), int'(e.strobe));
              check("strobe_count", st_n, (e.strobe != 3'b000) ? 1 : 0);
              check("cycle_detail", bad, 0);
              check("instr_count", int'(instr_count), int'(e.count));
              check("err", int'(err), int'(e.err));
            end
            pos = 0; bad = 0; st_n = 0; st_mask = 3'b000;
          end
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog expired at t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Stimulus: directed cases, random stream, reset abort, back-to-back wrap
  initial begin
    int n;
    int guard;
    int last;
    logic [7:0] ins;
    int k;
    rst_n = 1'b0; err_clr = 1'b0; bus.instr = 8'h00; bus.instr_valid = 1'b0;
    alu_k = 0; stray_req = 1'b0; mon_en = 1'b0;
    model_count = 8'h00; model_err = 1'b0;
    #12;
    check("rst_ready", int'(bus.instr_ready), 1);
    check("rst_outputs", int'({bus.alu_op, bus.alu_start, bus.latch_a, bus.latch_b, bus.latch_out,
                               bus.src_a_sel, bus.src_b_sel, busy, err, instr_count}), 0);

    // First accept on the first posedge after release
    @(negedge clk);
    rst_n = 1'b1; mon_en = 1'b1;
    sb_q.push_back(model(8'h90, 0, 1'b0));
    bus.instr = 8'h90; bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;

    issue(8'h06, 3, 1'b0);
    issue(8'hC0, 0, 1'b0);
    issue(8'hC0, 0, 1'b1);
    issue(8'h9C, 0, 1'b1);
    issue(8'h25, 0, 1'b0);
    issue(8'h47, T_C, 1'b0);
    issue(8'h5B, 1, 1'b1);
    issue(8'h84, 0, 1'b0);
    issue(8'hA3, 0, 1'b0);
    issue(8'hBF, 0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ins = 8'($urandom);
      k = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, T_C));
      issue(ins, k, ($urandom_range(0, 3) == 0));
    end
    drain();

    // Reset while waiting on the ALU, then a stray alu_done while idle
    mon_en = 1'b0;
    @(negedge clk);
    alu_k = 0; bus.instr = 8'h35; bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("in_wait_alu_op", int'(bus.alu_op), 3);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(bus.instr_ready), 1);
    check("abort_outputs", int'({bus.alu_op, bus.alu_start, bus.latch_a, bus.latch_b, bus.latch_out,
                                 err, instr_count}), 0);
    @(negedge clk);
    rst_n = 1'b1; mon_en = 1'b1;
    model_count = 8'h00; model_err = 1'b0;
    @(posedge clk);
    #1 stray_req = 1'b1;
    @(posedge clk);
    #1 stray_req = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_done_busy", int'(busy), 0);
    check("stray_done_count", int'(instr_count), 0);

    // 256 back-to-back output-a instructions with instr_valid held high
    for (int i = 0; i < 256; i++) sb_q.push_back(model(8'hB0, 0, 1'b0));
    bus.instr = 8'hB0;
    n = 0; guard = 0; last = 0;
    while (n < 256 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (bus.instr_ready) begin
        if (n > 0) check("accept_spacing", guard - last, 3);
        last = guard;
        n++;
        bus.instr_valid = 1'b1;
      end
    end
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    check("b2b_accepts", n, 256);
    drain();
    check("count_wrapped", int'(instr_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
